// File: rtl/occupancy_pkg.sv
// Shared types and constants for the multi-door occupancy counter.
// Door FSM state encoding, sensor patterns and width helpers.
package occupancy_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IN1   = 3'd1,
        S_IN2   = 3'd2,
        S_IN3   = 3'd3,
        S_OUT1  = 3'd4,
        S_OUT2  = 3'd5,
        S_OUT3  = 3'd6,
        S_ABORT = 3'd7
    } door_state_t;

    localparam logic [1:0] P00 = 2'b00;
    localparam logic [1:0] P10 = 2'b10;
    localparam logic [1:0] P11 = 2'b11;
    localparam logic [1:0] P01 = 2'b01;

    function automatic int net_w(input int ch);
        return $clog2(ch) + 2;
    endfunction

endpackage

// File: rtl/occupancy_counter_door_fsm.sv
// Per-door beam synchroniser and passage-classification FSM.
// The *_nxt outputs lead the registered pulses by one cycle.
module door_fsm
    import occupancy_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic ingreso,
    output logic egreso,
    output logic seq_err,
    output logic ingreso_nxt,
    output logic egreso_nxt
);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             ab;
    door_state_t            state;
    door_state_t            state_d;
    logic                   fire_in;
    logic                   fire_out;
    logic                   fire_err;
    logic                   err_nxt;

    assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // Bring the asynchronous beam levels into the clock domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b};
        end
    end

    // Next state: forward steps, legal back-outs, and aborts on skips.
    always_comb begin
        state_d  = state;
        fire_in  = 1'b0;
        fire_out = 1'b0;
        fire_err = 1'b0;
        unique case (state)
            S_IDLE: begin
                case (ab)
                    P10: state_d = S_IN1;
                    P01: state_d = S_OUT1;
                    P11: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_IN1: begin
                case (ab)
                    P11: state_d = S_IN2;
                    P00: state_d = S_IDLE;
                    P01: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_IN2: begin
                case (ab)
                    P01: state_d = S_IN3;
                    P10: state_d = S_IN1;
                    P00: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_IN3: begin
                case (ab)
                    P00: begin
                        state_d = S_IDLE;
                        fire_in = 1'b1;
                    end
                    P11: state_d = S_IN2;
                    P10: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_OUT1: begin
                case (ab)
                    P11: state_d = S_OUT2;
                    P00: state_d = S_IDLE;
                    P10: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_OUT2: begin
                case (ab)
                    P10: state_d = S_OUT3;
                    P01: state_d = S_OUT1;
                    P00: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_OUT3: begin
                case (ab)
                    P00: begin
                        state_d  = S_IDLE;
                        fire_out = 1'b1;
                    end
                    P11: state_d = S_OUT2;
                    P01: begin
                        state_d  = S_ABORT;
                        fire_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_ABORT: begin
                if (ab == P00) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus the one-cycle event stage ahead of the pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            ingreso_nxt <= 1'b0;
            egreso_nxt  <= 1'b0;
            err_nxt     <= 1'b0;
        end else begin
            state       <= state_d;
            ingreso_nxt <= fire_in;
            egreso_nxt  <= fire_out;
            err_nxt     <= fire_err;
        end
    end

    // Registered single-cycle event pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ingreso <= 1'b0;
            egreso  <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            ingreso <= ingreso_nxt;
            egreso  <= egreso_nxt;
            seq_err <= err_nxt;
        end
    end

endmodule

// File: rtl/occupancy_counter.sv
// Multi-door people counter with a shared saturating occupancy register.
// Entries and exits of one cycle are netted before clamping.
module occupancy_counter
    import occupancy_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 8,
    parameter int CAPACITY    = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    output logic [CHANNELS-1:0] ingreso,
    output logic [CHANNELS-1:0] egreso,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                underflow,
    output logic [CHANNELS-1:0] seq_err
);

    localparam int NW = net_w(CHANNELS);
    localparam int SW = CNT_W + NW;
    localparam logic [CNT_W-1:0]     CAP   = CNT_W'(CAPACITY);
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [CHANNELS-1:0]   in_nxt;
    logic [CHANNELS-1:0]   out_nxt;
    logic [NW-1:0]         n_in;
    logic [NW-1:0]         n_out;
    logic signed [NW-1:0]  net;
    logic signed [SW-1:0]  sum;
    logic [CNT_W-1:0]      count_d;
    logic                  ovf_hit;
    logic                  unf_hit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_door
        door_fsm #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_door (
            .clk         (clk),
            .reset       (reset),
            .a           (a[i]),
            .b           (b[i]),
            .ingreso     (ingreso[i]),
            .egreso      (egreso[i]),
            .seq_err     (seq_err[i]),
            .ingreso_nxt (in_nxt[i]),
            .egreso_nxt  (out_nxt[i])
        );
    end

    // Net passage count and the clamped next occupancy.
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_in  = n_in + NW'(in_nxt[i]);
            n_out = n_out + NW'(out_nxt[i]);
        end
        net     = $signed(n_in - n_out);
        sum     = $signed({{NW{1'b0}}, count}) + SW'(net);
        count_d = sum[CNT_W-1:0];
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        if (sum < 0) begin
            count_d = '0;
            unf_hit = 1'b1;
        end else if (sum > CAP_S) begin
            count_d = CAP;
            ovf_hit = 1'b1;
        end
    end

    // Occupancy register with full/empty and sticky range flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_d;
            full      <= (count_d == CAP);
            empty     <= (count_d == '0);
            overflow  <= overflow | ovf_hit;
            underflow <= underflow | unf_hit;
        end
    end

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench for occupancy_counter (2 doors, capacity 3).
// Passages are generated at door level; a clamp model tracks occupancy.
module tb_occupancy_counter;

    localparam int CH  = 2;
    localparam int CW  = 8;
    localparam int CAP = 3;
    localparam int SS  = 2;

    localparam int K_IDL = 0;
    localparam int K_ENT = 1;
    localparam int K_EXT = 2;
    localparam int K_BKI = 3;
    localparam int K_BKO = 4;
    localparam int K_JMP = 5;
    localparam int K_SKP = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] a = '0;
    logic [CH-1:0] b = '0;
    logic [CH-1:0] ingreso;
    logic [CH-1:0] egreso;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
    logic [CH-1:0] seq_err;

    int checks = 0;
    int errors = 0;
    int seen_in[CH];
    int seen_out[CH];
    int seen_err[CH];
    int exp_in[CH];
    int exp_out[CH];
    int exp_err[CH];
    int m_cnt = 0;
    int m_ovf = 0;
    int m_unf = 0;

    occupancy_counter #(
        .CHANNELS    (CH),
        .CNT_W       (CW),
        .CAPACITY    (CAP),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .ingreso   (ingreso),
        .egreso    (egreso),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    // Count high samples so a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (ingreso[i] === 1'b1) seen_in[i]++;
            if (egreso[i] === 1'b1) seen_out[i]++;
            if (seq_err[i] === 1'b1) seen_err[i]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set2(input logic [1:0] d0, input logic [1:0] d1);
        a = {d1[1], d0[1]};
        b = {d1[0], d0[0]};
    endtask

    function automatic logic [7:0] seq_of(input int k);
        case (k)
            K_ENT:   return 8'b10_11_01_00;
            K_EXT:   return 8'b01_11_10_00;
            K_BKI:   return 8'b10_11_10_00;
            K_BKO:   return 8'b01_11_01_00;
            K_JMP:   return 8'b11_01_00_00;
            K_SKP:   return 8'b10_01_00_00;
            default: return 8'b00_00_00_00;
        endcase
    endfunction

    task automatic model(input int nin, input int nout);
        int r;
        r = m_cnt + nin - nout;
        if (r > CAP) begin
            m_ovf = 1;
            r = CAP;
        end
        if (r < 0) begin
            m_unf = 1;
            r = 0;
        end
        m_cnt = r;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == CAP));
        chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("%s.in%0d", tag, i), seen_in[i], exp_in[i]);
            chk($sformatf("%s.out%0d", tag, i), seen_out[i], exp_out[i]);
            chk($sformatf("%s.err%0d", tag, i), seen_err[i], exp_err[i]);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".ovf"}, 32'(overflow), 0);
        chk({tag, ".unf"}, 32'(underflow), 0);
        chk({tag, ".ingreso"}, 32'(ingreso), 0);
        chk({tag, ".egreso"}, 32'(egreso), 0);
        chk({tag, ".seq_err"}, 32'(seq_err), 0);
    endtask

    // Both doors step together; h == 0 picks a random hold per step.
    task automatic txn(input string tag, input int k0, input int k1,
                       input int h);
        logic [7:0] s0;
        logic [7:0] s1;
        int ks[CH];
        int nin;
        int nout;
        s0 = seq_of(k0);
        s1 = seq_of(k1);
        ks[0] = k0;
        ks[1] = k1;
        for (int s = 0; s < 4; s++) begin
            set2(s0[(3-s)*2 +: 2], s1[(3-s)*2 +: 2]);
            hold(h == 0 ? int'($urandom_range(1, 3)) : h);
        end
        hold(6);
        nin  = 0;
        nout = 0;
        for (int i = 0; i < CH; i++) begin
            if (ks[i] == K_ENT) begin
                exp_in[i]++;
                nin++;
            end
            if (ks[i] == K_EXT) begin
                exp_out[i]++;
                nout++;
            end
            if (ks[i] == K_JMP || ks[i] == K_SKP) exp_err[i]++;
        end
        model(nin, nout);
        chk_model(tag);
    endtask

    initial begin
        reset = 1'b0;
        set2(2'b00, 2'b00);
        hold(3);
        chk_reset("rst");
        reset = 1'b1;
        hold(2);

        set2(2'b10, 2'b00);
        hold(4);
        set2(2'b11, 2'b00);
        hold(4);
        set2(2'b01, 2'b00);
        hold(4);
        set2(2'b00, 2'b00);
        hold(3);
        chk("lat.early", 32'(ingreso[0]), 0);
        chk("lat.early_cnt", 32'(count), 0);
        hold(1);
        chk("lat.pulse", 32'(ingreso[0]), 1);
        chk("lat.count", 32'(count), 1);
        chk("lat.empty", 32'(empty), 0);
        hold(1);
        chk("lat.drop", 32'(ingreso[0]), 0);
        hold(4);
        exp_in[0]++;
        model(1, 0);
        chk_model("entry0");

        txn("exit1", K_IDL, K_EXT, 4);
        txn("exit1_unf", K_IDL, K_EXT, 4);
        txn("backout0", K_BKI, K_IDL, 4);
        txn("jump0", K_JMP, K_IDL, 4);
        txn("entry_after_abort", K_ENT, K_IDL, 4);
        txn("entry2", K_ENT, K_IDL, 4);
        txn("entry3_full", K_IDL, K_ENT, 4);
        txn("cancel_at_cap", K_ENT, K_EXT, 4);
        txn("dual_ovf", K_ENT, K_ENT, 4);

        set2(2'b10, 2'b00);
        hold(4);
        set2(2'b11, 2'b00);
        hold(4);
        reset = 1'b0;
        hold(3);
        chk_reset("rst_mid");
        set2(2'b01, 2'b00);
        hold(1);
        reset = 1'b1;
        hold(4);
        set2(2'b00, 2'b00);
        hold(8);
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
        chk_model("after_rst");

        for (int t = 0; t < 30; t++) begin
            txn($sformatf("rnd%0d", t), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
